vector_config_unit: RTL

//  Holds vector architectural state (vl, vtype, vstart) and executes vsetvli/vsetivli/vsetvl.

---
 rtl/vector_config_unit.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/vector_config_unit.sv
// Vector configuration unit: holds vl/vtype/vstart, executes vsetvli/vsetivli/vsetvl,
// drives the element counter and serves the vector CSRs.
module vector_config_unit #(
  parameter int VLEN = 128,
  parameter int ELEN = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vset_en,
  input  logic [1:0]  vset_kind,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [10:0] zimm,
  input  logic [4:0]  uimm,
  input  logic        rs1_is_x0,
  input  logic        rd_is_x0,
  input  logic        stall,
  input  logic        csr_wen,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  input  logic        trap,
  input  logic [31:0] ec_offset,
  input  logic        ec_done,
  output logic [31:0] vl,
  output logic [31:0] vstart,
  output logic [1:0]  sew,
  output logic [2:0]  lmul,
  output logic        vill,
  output logic [31:0] vlmax,
  output logic        ec_clear,
  output logic [31:0] rd_wdata,
  output logic [31:0] csr_rdata
);

  localparam int          VSTART_W = $clog2(VLEN);
  localparam logic [31:0] VLEN_W   = 32'(VLEN);
  localparam logic [31:0] ELEN_W   = 32'(ELEN);
  localparam logic [31:0] VLENB    = 32'(VLEN / 8);

  localparam logic [1:0] KIND_VSETVLI  = 2'b00;
  localparam logic [1:0] KIND_VSETIVLI = 2'b01;
  localparam logic [1:0] KIND_VSETVL   = 2'b10;

  localparam logic [11:0] CSR_VSTART = 12'h008;
  localparam logic [11:0] CSR_VL     = 12'hC20;
  localparam logic [11:0] CSR_VTYPE  = 12'hC21;
  localparam logic [11:0] CSR_VLENB  = 12'hC22;

  localparam logic [2:0] VLMUL_RSVD = 3'b100;
  localparam logic [2:0] VSEW_MAX   = 3'b010;

  // Architectural state. vtype_q holds {vma, vta, vsew, vlmul}; vill is kept apart.
  logic [31:0] vl_q;
  logic [31:0] vstart_q;
  logic [7:0]  vtype_q;
  logic        vill_q;
  logic        ec_clear_q;

  // VLMAX = (VLEN/SEW)*LMUL. Fractional LMUL 111/110/101 shifts right by 1/2/3,
  // which is exactly the 3-bit two's-complement negation of the encoding.
  function automatic logic [31:0] calc_vlmax(input logic [2:0] vsew, input logic [2:0] vlmul);
    logic [31:0] per_reg;
    per_reg = VLEN_W >> (32'd3 + 32'(vsew));
    if (!vlmul[2]) calc_vlmax = per_reg << vlmul[1:0];
    else           calc_vlmax = per_reg >> (3'd0 - vlmul);
  endfunction

  logic [31:0] cand_vtype;
  logic [2:0]  cand_vsew;
  logic [2:0]  cand_vlmul;
  logic [31:0] cand_vlmax;
  logic        cand_ill;
  logic        keep_vl;
  logic [31:0] avl;
  logic        new_ill;
  logic [31:0] new_vl;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    cand_vtype = '0;
    case (vset_kind)
      KIND_VSETVLI:  cand_vtype = {21'b0, zimm};
      KIND_VSETIVLI: cand_vtype = {22'b0, zimm[9:0]};
      KIND_VSETVL:   cand_vtype = rs2_data;
      default:       cand_vtype = '0;
    endcase
  end

  assign cand_vsew  = cand_vtype[5:3];
  assign cand_vlmul = cand_vtype[2:0];
  assign cand_vlmax = calc_vlmax(cand_vsew, cand_vlmul);

  assign cand_ill = (|cand_vtype[31:8])
                 || (cand_vlmul == VLMUL_RSVD)
                 || (cand_vsew > VSEW_MAX)
                 || ((32'd8 << cand_vsew) > ELEN_W)
                 || (cand_vlmax == 32'd0);

  // rs1=x0 and rd=x0 (register forms only) keeps the current vl under the new vtype.
  assign keep_vl = (vset_kind != KIND_VSETIVLI) && rs1_is_x0 && rd_is_x0;

  always_comb begin
    avl = cand_vlmax;
    if (vset_kind == KIND_VSETIVLI) avl = {27'b0, uimm};
    else if (!rs1_is_x0)            avl = rs1_data;
  end

  assign new_ill = cand_ill || (keep_vl && (vl_q > cand_vlmax));

  always_comb begin
    new_vl = '0;
    if (new_ill)                 new_vl = '0;
    else if (keep_vl)            new_vl = vl_q;
    else if (avl < cand_vlmax)   new_vl = avl;
    else                         new_vl = cand_vlmax;
  end

  logic vset_commit;
  logic csr_vstart_wr;
  logic ec_retire;

  // A trap in the same cycle squashes the vset; reserved kind 11 never commits.
  assign vset_commit   = vset_en && (vset_kind != 2'b11) && !stall && !trap;
  assign csr_vstart_wr = csr_wen && (csr_addr == CSR_VSTART) && !stall;
  assign ec_retire     = ec_done && !stall;

  // NOTE: all state is written with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vl_q    <= '0;
      vtype_q <= '0;
      vill_q  <= 1'b1;
    end else if (vset_commit) begin
      vl_q    <= new_vl;
      vill_q  <= new_ill;
      vtype_q <= new_ill ? 8'h00 : cand_vtype[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vstart_q <= '0;
    end else if (trap) begin
      vstart_q <= ec_offset;
    end else if (csr_vstart_wr) begin
      vstart_q <= {{(32-VSTART_W){1'b0}}, csr_wdata[VSTART_W-1:0]};
    end else if (ec_retire || vset_commit) begin
      vstart_q <= '0;
    end
  end

  // The counter restarts after any vset commit, and after a retirement that won vstart priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ec_clear_q <= 1'b0;
    else        ec_clear_q <= vset_commit || (ec_retire && !trap && !csr_vstart_wr);
  end

  logic unused_csr_wdata;
  assign unused_csr_wdata = ^csr_wdata[31:VSTART_W];

  assign vl       = vl_q;
  assign vstart   = vstart_q;
  assign sew      = vtype_q[4:3];
  assign lmul     = vtype_q[2:0];
  assign vill     = vill_q;
  assign vlmax    = vill_q ? 32'd0 : calc_vlmax(vtype_q[5:3], vtype_q[2:0]);
  assign ec_clear = ec_clear_q;
  assign rd_wdata = new_vl;

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      CSR_VSTART: csr_rdata = vstart_q;
      CSR_VL:     csr_rdata = vl_q;
      CSR_VTYPE:  csr_rdata = {vill_q, 23'b0, vtype_q};
      CSR_VLENB:  csr_rdata = VLENB;
      default:    csr_rdata = '0;
    endcase
  end

endmodule
